// File: rtl/sram_b_pkg.sv
// Shared definitions for the SRAM_B controller: geometry constants, the burst
// FSM state encoding and the wrap-around address increment.
package sram_b_pkg;

  localparam int WORDS  = 56;
  localparam int DATA_W = 130;
  localparam int ADDR_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Next address in the buffer; the last word wraps back to word 0.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr);
    if (addr == ADDR_W'(WORDS - 1)) begin
      return '0;
    end
    return addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/sram_b_arb.sv
// Two-requester grant logic for the single SRAM_B port (read issue vs write).
// Build option SRAM_B_RR_EN: when defined, read issue and write alternate on
// contention during READ (read first after reset or burst start); otherwise a
// read issue always wins and writes wait until the port is free.
module sram_b_arb
  import sram_b_pkg::*;
(
`ifdef SRAM_B_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
`endif
  input  state_t state,
  input  logic   rd_req,
  input  logic   wr_req,
  output logic   rd_gnt,
  output logic   wr_gnt
);

`ifdef SRAM_B_RR_EN
  logic favour_rd;

  // Round-robin pointer: flips after every contended READ cycle.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      favour_rd <= 1'b1;
    end else if (state == READ && rd_req && wr_req) begin
      favour_rd <= ~favour_rd;
    end
  end

  // Grant: alternate on contention in READ, otherwise serve whoever asks.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (state == READ) begin
      if (rd_req && wr_req) begin
        rd_gnt = favour_rd;
        wr_gnt = ~favour_rd;
      end else begin
        rd_gnt = rd_req;
        wr_gnt = wr_req;
      end
    end else begin
      wr_gnt = wr_req;
    end
  end
`else
  // Grant: the read stream owns the port for the whole READ state.
  always_comb begin
    rd_gnt = rd_req && (state == READ);
    wr_gnt = wr_req && (state != READ);
  end
`endif

endmodule

// File: rtl/sram_b_ctrl.sv
// SRAM_B sequencing controller: shares one single-port SRAM between a word
// loader (wr_*) and a burst reader (rd_*), generates wrapping burst addresses
// and aligns the 1-cycle SRAM read data with rd_data_valid / rd_last.
// Build option SRAM_B_RR_EN selects round-robin read/write arbitration during
// READ (see sram_b_arb); the default build gives reads fixed priority.
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
// wr_ready is combinational and the word lands in the SRAM at that same edge.
// The read side has no backpressure: every cycle rd_data_valid is high the
// consumer must take rd_data, and rd_last marks the final word of the burst.
//
// The wrap increment comes from sram_b_pkg, so WORDS/ADDR_W are expected to
// stay at their package values.
module sram_b_ctrl #(
  parameter int WORDS  = sram_b_pkg::WORDS,
  parameter int DATA_W = sram_b_pkg::DATA_W,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              rd_busy,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  import sram_b_pkg::state_t;
  import sram_b_pkg::IDLE;
  import sram_b_pkg::READ;
  import sram_b_pkg::DRAIN;
  import sram_b_pkg::wrap_inc;

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(WORDS);

  state_t            state;
  logic [ADDR_W-1:0] issue_ptr;
  logic [ADDR_W:0]   remaining;
  logic              dv_q;
  logic              last_q;

  logic              rd_req;
  logic              wr_req;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              burst_start;
  logic [ADDR_W:0]   len_clamped;

  // Oversized bursts read the whole buffer once; zero-length starts are dropped.
  assign len_clamped = (rd_len > LEN_MAX) ? LEN_MAX : rd_len;
  assign burst_start = !rst && (state == IDLE) && rd_start && (rd_len != '0);
  assign rd_req      = !rst && (state == READ);
  assign wr_req      = !rst && wr_valid;

  sram_b_arb u_arb (
`ifdef SRAM_B_RR_EN
    .clk    (clk),
    .rst    (rst),
    .start  (burst_start),
`endif
    .state  (state),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .rd_gnt (rd_gnt),
    .wr_gnt (wr_gnt)
  );

  // Burst FSM, issue pointer / remaining count and the valid/last pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_ptr <= '0;
      remaining <= '0;
      dv_q      <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      dv_q   <= rd_gnt;
      last_q <= rd_gnt && (remaining == LEN_ONE);
      case (state)
        IDLE: begin
          if (burst_start) begin
            issue_ptr <= rd_base;
            remaining <= len_clamped;
            state     <= READ;
          end
        end
        READ: begin
          if (rd_gnt) begin
            issue_ptr <= wrap_inc(issue_ptr);
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // SRAM port mux: read issue, granted write, or an idle port driven to zero.
  always_comb begin
    sram_we   = wr_gnt;
    sram_addr = '0;
    sram_din  = '0;
    if (rd_gnt) begin
      sram_addr = issue_ptr;
    end else if (wr_gnt) begin
      sram_addr = wr_addr;
      sram_din  = wr_data;
    end
  end

  assign wr_ready      = wr_gnt;
  assign rd_busy       = !rst && (state != IDLE);
  assign rd_data_valid = !rst && dv_q;
  assign rd_last       = !rst && last_q;
  assign rd_data       = sram_dout;

endmodule

// File: tb/tb_sram_b_ctrl.sv
// Bench for sram_b_ctrl (default build, fixed read priority) with a behavioural
// 1-cycle registered SRAM and a scoreboard of expected {last, data} words.
module tb_sram_b_ctrl;

  localparam int WORDS  = 56;
  localparam int DATA_W = 130;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W:0]   rd_len;
  logic              rd_busy;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  logic [DATA_W-1:0] mem     [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W:0]   exp_word;

  int checks     = 0;
  int passed     = 0;
  int last_count = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- DUT and SRAM model ----------------
  sram_b_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_start      (rd_start),
    .rd_base       (rd_base),
    .rd_len        (rd_len),
    .rd_busy       (rd_busy),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout)
  );

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && rd_data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_word: got last=%b data=%h, required no word", rd_last, rd_data);
      end else begin
        exp_word = exp_q.pop_front();
        if ({rd_last, rd_data} !== exp_word)
          $display("FAIL burst_word: got last=%b data=%h, required last=%b data=%h",
                   rd_last, rd_data, exp_word[DATA_W], exp_word[DATA_W-1:0]);
        else
          passed++;
      end
    end
    if (!rst && rd_last) last_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int base, input int eff);
    int a;
    for (int i = 0; i < eff; i++) begin
      a = (base + i) % WORDS;
      exp_q.push_back({(i == eff - 1) ? 1'b1 : 1'b0, ref_mem[a]});
    end
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    int n;
    bit done;
    logic [ADDR_W-1:0] ea;
    ea = ADDR_W'(a);
    wr_valid = 1'b1; wr_addr = ea; wr_data = d;
    done = 1'b0; n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (wr_ready === 1'b1) begin
        checks++;
        if (sram_we !== 1'b1 || sram_addr !== ea || sram_din !== d)
          $display("FAIL write_port: got we=%b addr=%0d din=%h, required we=1 addr=%0d din=%h",
                   sram_we, sram_addr, sram_din, ea, d);
        else
          passed++;
        done = 1'b1;
      end
      n++;
      step();
    end
    wr_valid = 1'b0;
    if (done) ref_mem[a] = d;
    else begin
      checks++;
      $display("FAIL write_timeout: got no wr_ready in 200 cycles, required a grant (addr %0d)", a);
    end
  endtask

  // Start a burst with no write traffic and check the cycle-exact timing.
  task automatic run_burst(input string name, input int base, input int len);
    int eff;
    logic [ADDR_W-1:0] ea;
    eff = (len > WORDS) ? WORDS : len;
    rd_start = 1'b1; rd_base = ADDR_W'(base); rd_len = (ADDR_W+1)'(len);
    push_burst(base, eff);
    step();
    rd_start = 1'b0;
    for (int k = 1; k <= eff + 2; k++) begin
      @(negedge clk);
      checks++;
      if (rd_busy !== (k <= eff + 1) || rd_last !== (k == eff + 1) ||
          rd_data_valid !== (k >= 2 && k <= eff + 1))
        $display("FAIL %s_timing: cycle T+%0d got busy=%b valid=%b last=%b, required busy=%b valid=%b last=%b",
                 name, k, rd_busy, rd_data_valid, rd_last, (k <= eff + 1),
                 (k >= 2 && k <= eff + 1), (k == eff + 1));
      else
        passed++;
      if (k <= eff) begin
        ea = ADDR_W'((base + k - 1) % WORDS);
        checks++;
        if (sram_addr !== ea || sram_we !== 1'b0 || sram_din !== '0)
          $display("FAIL %s_issue: cycle T+%0d got addr=%0d we=%b, required addr=%0d we=0",
                   name, k, sram_addr, sram_we, ea);
        else
          passed++;
      end
    end
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 6'd9; wr_data = '1;
    rd_start = 1'b1; rd_base = '0; rd_len = 7'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({wr_ready, rd_busy, rd_data_valid, rd_last, sram_we} !== 5'b0 ||
          sram_addr !== '0 || sram_din !== '0)
        $display("FAIL reset_outputs: got ready=%b busy=%b valid=%b last=%b we=%b addr=%0d, required all 0",
                 wr_ready, rd_busy, rd_data_valid, rd_last, sram_we, sram_addr);
      else
        passed++;
      step();
    end
    rst = 1'b0; wr_valid = 1'b0; rd_start = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_busy !== 1'b0 || sram_we !== 1'b0 || sram_addr !== '0)
      $display("FAIL post_reset_idle: got busy=%b we=%b addr=%0d, required 0 0 0", rd_busy, sram_we, sram_addr);
    else
      passed++;
    step();
  endtask

  task automatic test_full_burst();
    for (int a = 0; a < WORDS; a++) do_write(a, DATA_W'(a * 3));
    run_burst("full", 0, 56);
  endtask

  task automatic test_wrap();
    run_burst("wrap", 50, 10);
  endtask

  task automatic test_len_zero_and_clamp();
    rd_start = 1'b1; rd_base = 6'd3; rd_len = '0;
    step();
    rd_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rd_busy !== 1'b0 || rd_data_valid !== 1'b0 || sram_addr !== '0)
        $display("FAIL len_zero: got busy=%b valid=%b addr=%0d, required 0 0 0", rd_busy, rd_data_valid, sram_addr);
      else
        passed++;
      step();
    end
    run_burst("clamp", 0, 70);
  endtask

  task automatic test_write_contention();
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, 2'b01};
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = d;
    rd_start = 1'b1; rd_base = 6'd10; rd_len = 7'd4;
    push_burst(10, 4);
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 6'd7)
      $display("FAIL contention_idle_grant: got ready=%b we=%b addr=%0d, required 1 1 7", wr_ready, sram_we, sram_addr);
    else
      passed++;
    step();
    ref_mem[7] = d;
    rd_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b0 || sram_addr !== ADDR_W'(9 + k))
        $display("FAIL contention_read: cycle T+%0d got ready=%b addr=%0d, required 0 %0d", k, wr_ready, sram_addr, 9 + k);
      else
        passed++;
      step();
    end
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || rd_last !== 1'b1 || sram_addr !== 6'd7)
      $display("FAIL contention_drain: got ready=%b last=%b addr=%0d, required 1 1 7", wr_ready, rd_last, sram_addr);
    else
      passed++;
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_busy !== 1'b0)
      $display("FAIL contention_end: got busy=%b, required 0", rd_busy);
    else
      passed++;
    step();
  endtask

  task automatic test_reset_mid_burst();
    int lc0;
    lc0 = last_count;
    rd_start = 1'b1; rd_base = 6'd20; rd_len = 7'd8;
    push_burst(20, 8);
    step();
    rd_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      step();
    end
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_busy !== 1'b0 || rd_data_valid !== 1'b0 || wr_ready !== 1'b0 || sram_addr !== '0)
      $display("FAIL abort_outputs: got busy=%b valid=%b ready=%b addr=%0d, required 0 0 0 0",
               rd_busy, rd_data_valid, wr_ready, sram_addr);
    else
      passed++;
    step();
    for (int c = 0; c < 10; c++) step();
    checks++;
    if (last_count !== lc0)
      $display("FAIL abort_no_last: got %0d rd_last pulses, required %0d", last_count, lc0);
    else
      passed++;
  endtask

  task automatic test_same_addr();
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, 2'b10};
    rd_start = 1'b1; rd_base = 6'd5; rd_len = 7'd1;
    push_burst(5, 1);
    step();
    rd_start = 1'b0;
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = d;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0 || sram_addr !== 6'd5 || sram_we !== 1'b0)
      $display("FAIL raw_issue: got ready=%b addr=%0d we=%b, required 0 5 0", wr_ready, sram_addr, sram_we);
    else
      passed++;
    step();
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || rd_last !== 1'b1 || sram_addr !== 6'd5)
      $display("FAIL raw_write: got ready=%b last=%b addr=%0d, required 1 1 5", wr_ready, rd_last, sram_addr);
    else
      passed++;
    step();
    ref_mem[5] = d;
    wr_valid = 1'b0;
    run_burst("reread", 5, 2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0;
    test_reset();
    test_full_burst();
    test_wrap();
    test_len_zero_and_clamp();
    test_write_contention();
    test_reset_mid_burst();
    test_same_addr();
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL leftover_words: got %0d words still expected, required 0", exp_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
